// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction-fetch stage: PC, synchronous memory read, valid/ready issue, redirect, halt
module instr_fetch #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter bit                    HALT_ENABLE = 1'b1,
  parameter logic [15:0]           HALT_WORD   = 16'hFFFF
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Run,
  output logic [ADDR_WIDTH-1:0] o_MemAddr,
  output logic                  o_MemRead,
  input  logic [15:0]           i_MemData,
  output logic [15:0]           o_Instruction,
  output logic                  o_InstrValid,
  input  logic                  i_InstrReady,
  output logic [ADDR_WIDTH-1:0] o_InstrPC,
  input  logic                  i_Redirect,
  input  logic [ADDR_WIDTH-1:0] i_RedirectTarget,
  output logic                  o_Halted
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_ISSUE   = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_mem_read;
  logic [15:0]           r_instr;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic                  r_halted;
  logic                  w_is_halt;

  assign w_is_halt = HALT_ENABLE && (i_MemData == HALT_WORD);

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_mem_read <= 1'b0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_instr_pc <= '0;
      r_halted   <= 1'b0;
    end else if (i_Redirect) begin
      // A redirect in ISSUE with InstrReady high still counts as the accepted transfer.
      r_pc     <= i_RedirectTarget;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      if (r_state == S_IDLE) begin
        r_state    <= S_IDLE;
        r_mem_read <= 1'b0;
      end else begin
        r_state    <= S_FETCH;
        r_mem_read <= 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_Run) begin
            r_state    <= S_FETCH;
            r_mem_read <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state    <= S_CAPTURE;
          r_mem_read <= 1'b0;
        end
        S_CAPTURE: begin
          if (w_is_halt) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_state    <= S_ISSUE;
            r_instr    <= i_MemData;
            r_instr_pc <= r_pc;
            r_pc       <= r_pc + 1'b1;
            r_valid    <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (i_InstrReady) begin
            r_state    <= S_FETCH;
            r_valid    <= 1'b0;
            r_mem_read <= 1'b1;
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state    <= S_IDLE;
          r_mem_read <= 1'b0;
          r_valid    <= 1'b0;
        end
      endcase
    end
  end

  assign o_MemAddr     = r_pc;
  assign o_MemRead     = r_mem_read;
  assign o_Instruction = r_instr;
  assign o_InstrValid  = r_valid;
  assign o_InstrPC     = r_instr_pc;
  assign o_Halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with a transaction-level issue model
module tb_instr_fetch;

  logic        clk;
  logic        rst_n, run, ready, redir;
  logic [15:0] target, memaddr, memdata, instr, ipc;
  logic        memread, ivalid, halted;

  logic        rst_n2, run2, ready2, redir2;
  logic [15:0] target2, memaddr2, memdata2, instr2, ipc2;
  logic        memread2, ivalid2, halted2;

  logic [15:0] mem0 [0:65535];
  logic [15:0] mem2 [0:65535];

  int total = 0;
  int bad   = 0;

  instr_fetch dut (
    .i_Clock(clk), .i_Reset(rst_n), .i_Run(run),
    .o_MemAddr(memaddr), .o_MemRead(memread), .i_MemData(memdata),
    .o_Instruction(instr), .o_InstrValid(ivalid), .i_InstrReady(ready),
    .o_InstrPC(ipc), .i_Redirect(redir), .i_RedirectTarget(target),
    .o_Halted(halted)
  );

  instr_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFF), .HALT_ENABLE(1'b0), .HALT_WORD(16'hFFFF)) dut2 (
    .i_Clock(clk), .i_Reset(rst_n2), .i_Run(run2),
    .o_MemAddr(memaddr2), .o_MemRead(memread2), .i_MemData(memdata2),
    .o_Instruction(instr2), .o_InstrValid(ivalid2), .i_InstrReady(ready2),
    .o_InstrPC(ipc2), .i_Redirect(redir2), .i_RedirectTarget(target2),
    .o_Halted(halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    if (memread)  memdata  <= mem0[memaddr];
    if (memread2) memdata2 <= mem2[memaddr2];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total += 6;
    if (memread !== 1'b0) begin bad++; $display("FAIL reset_memread got %b exp 0", memread); end
    if (ivalid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", ivalid); end
    if (instr !== 16'h0) begin bad++; $display("FAIL reset_instr got %h exp 0000", instr); end
    if (ipc !== 16'h0) begin bad++; $display("FAIL reset_ipc got %h exp 0000", ipc); end
    if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got %b exp 0", halted); end
    if (memaddr !== 16'h0) begin bad++; $display("FAIL reset_memaddr got %h exp 0000", memaddr); end
    rst_n = 1'b1; redir = 1'b1; target = 16'h1234;
    tick();
    redir = 1'b0;
    total += 2;
    if (memaddr !== 16'h1234) begin bad++; $display("FAIL idle_redirect_addr got %h exp 1234", memaddr); end
    if (memread !== 1'b0) begin bad++; $display("FAIL idle_redirect_memread got %b exp 0", memread); end
    tick();
    total++;
    if (memread !== 1'b0) begin bad++; $display("FAIL idle_stays_idle got %b exp 0", memread); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    run = 1'b1;
    tick();
    run = 1'b0;
    total += 3;
    if (memread !== 1'b1) begin bad++; $display("FAIL ff_memread got %b exp 1", memread); end
    if (memaddr !== 16'h0) begin bad++; $display("FAIL ff_memaddr got %h exp 0000", memaddr); end
    if (ivalid !== 1'b0) begin bad++; $display("FAIL ff_valid_early got %b exp 0", ivalid); end
    tick();
    total++;
    if (ivalid !== 1'b0 || memread !== 1'b0) begin bad++; $display("FAIL ff_capture got v=%b r=%b exp 0 0", ivalid, memread); end
    tick();
    total += 4;
    if (ivalid !== 1'b1) begin bad++; $display("FAIL ff_valid got %b exp 1", ivalid); end
    if (instr !== 16'h5101) begin bad++; $display("FAIL ff_instr got %h exp 5101", instr); end
    if (ipc !== 16'h0) begin bad++; $display("FAIL ff_ipc got %h exp 0000", ipc); end
    if (memaddr !== 16'h1) begin bad++; $display("FAIL ff_pc got %h exp 0001", memaddr); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (ivalid !== 1'b1 || instr !== 16'h5101 || ipc !== 16'h0 || memread !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got v=%b i=%h pc=%h r=%b exp 1 5101 0000 0", i, ivalid, instr, ipc, memread);
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++;
    if (memread !== 1'b1 || memaddr !== 16'h1 || ivalid !== 1'b0) begin
      bad++; $display("FAIL stall_release got r=%b a=%h v=%b exp 1 0001 0", memread, memaddr, ivalid);
    end
  endtask

  task automatic test_redirect_capture();
    tick(); tick();
    total++;
    if (ivalid !== 1'b1 || ipc !== 16'h1 || instr !== mem0[1]) begin
      bad++; $display("FAIL rc_issue1 got v=%b pc=%h i=%h exp 1 0001 %h", ivalid, ipc, instr, mem0[1]);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    total++;
    if (memaddr !== 16'h2 || memread !== 1'b0) begin bad++; $display("FAIL rc_capture2 got a=%h r=%b exp 0002 0", memaddr, memread); end
    redir = 1'b1; target = 16'h0040;
    tick();
    redir = 1'b0;
    total++;
    if (memread !== 1'b1 || memaddr !== 16'h0040 || ivalid !== 1'b0) begin
      bad++; $display("FAIL rc_refetch got r=%b a=%h v=%b exp 1 0040 0", memread, memaddr, ivalid);
    end
    tick();
    total++;
    if (ivalid !== 1'b0) begin bad++; $display("FAIL rc_flushed got v=%b exp 0", ivalid); end
    tick();
    total++;
    if (ivalid !== 1'b1 || ipc !== 16'h0040 || instr !== mem0[16'h40]) begin
      bad++; $display("FAIL rc_issue40 got v=%b pc=%h i=%h exp 1 0040 %h", ivalid, ipc, instr, mem0[16'h40]);
    end
  endtask

  task automatic test_redirect_issue();
    logic [15:0] tgt;
    int          accepted;
    tgt = 16'h0080 + 16'($urandom_range(0, 63));
    accepted = 0;
    redir = 1'b1; ready = 1'b1; target = tgt;
    if (ivalid && ready) accepted++;
    tick();
    redir = 1'b0; ready = 1'b0;
    total += 2;
    if (accepted !== 1) begin bad++; $display("FAIL ri_accepted got %0d exp 1", accepted); end
    if (ivalid !== 1'b0 || memread !== 1'b1 || memaddr !== tgt) begin
      bad++; $display("FAIL ri_fetch got v=%b r=%b a=%h exp 0 1 %h", ivalid, memread, memaddr, tgt);
    end
    tick(); tick();
    total++;
    if (ivalid !== 1'b1 || ipc !== tgt || instr !== mem0[tgt]) begin
      bad++; $display("FAIL ri_issue got v=%b pc=%h i=%h exp 1 %h %h", ivalid, ipc, instr, tgt, mem0[tgt]);
    end
  endtask

  task automatic test_halt();
    int k;
    k = 0;
    redir = 1'b1; target = 16'h0;
    tick();
    redir = 1'b0; ready = 1'b1;
    for (int c = 0; c < 30 && !halted; c++) begin
      if (ivalid && ready) begin
        total++;
        if (ipc !== 16'(k) || instr !== mem0[k]) begin
          bad++; $display("FAIL halt_stream got pc=%h i=%h exp %h %h", ipc, instr, 16'(k), mem0[k]);
        end
        k++;
      end
      tick();
    end
    total += 3;
    if (halted !== 1'b1) begin bad++; $display("FAIL halt_timeout got halted=%b exp 1", halted); end
    if (k !== 3) begin bad++; $display("FAIL halt_count got %0d exp 3", k); end
    if (memaddr !== 16'h3 || ivalid !== 1'b0 || memread !== 1'b0) begin
      bad++; $display("FAIL halt_state got a=%h v=%b r=%b exp 0003 0 0", memaddr, ivalid, memread);
    end
    tick(); tick();
    total++;
    if (halted !== 1'b1 || ivalid !== 1'b0 || memread !== 1'b0) begin
      bad++; $display("FAIL halt_hold got h=%b v=%b r=%b exp 1 0 0", halted, ivalid, memread);
    end
    redir = 1'b1; target = 16'h0;
    tick();
    redir = 1'b0;
    total++;
    if (halted !== 1'b0 || memread !== 1'b1 || memaddr !== 16'h0) begin
      bad++; $display("FAIL halt_resume got h=%b r=%b a=%h exp 0 1 0000", halted, memread, memaddr);
    end
  endtask

  // Model: issued words form consecutive addresses from the last redirect target.
  task automatic test_random();
    logic [15:0] exp_pc;
    int          n_issued, n_thru;
    logic [15:0] tgt;
    n_issued = 0;
    exp_pc = 16'h0100;
    redir = 1'b1; target = 16'h0100; ready = 1'b0;
    tick();
    redir = 1'b0;
    for (int c = 0; c < 600; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 19) == 0);
      tgt = 16'h0100 + 16'($urandom_range(0, 200));
      target = tgt;
      #1;
      if (memread && ivalid) begin
        total++; bad++; $display("FAIL rnd_exclusive got r=%b v=%b exp not both", memread, ivalid);
      end
      if (ivalid && ready) begin
        total++;
        if (ipc !== exp_pc || instr !== mem0[exp_pc]) begin
          bad++; $display("FAIL rnd_issue got pc=%h i=%h exp %h %h", ipc, instr, exp_pc, mem0[exp_pc]);
        end
        exp_pc++;
        n_issued++;
      end
      if (redir) exp_pc = tgt;
      tick();
    end
    redir = 1'b0;
    total++;
    if (n_issued < 50) begin bad++; $display("FAIL rnd_progress got %0d exp >=50", n_issued); end
    ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    n_thru = 0;
    for (int c = 0; c < 30; c++) begin
      if (ivalid && ready) n_thru++;
      tick();
    end
    total++;
    if (n_thru !== 10) begin bad++; $display("FAIL rnd_throughput got %0d exp 10", n_thru); end
    ready = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    rst_n2 = 1'b1; run2 = 1'b1;
    tick();
    run2 = 1'b0;
    tick(); tick();
    total++;
    if (ivalid2 !== 1'b1 || ipc2 !== 16'hFFFF || instr2 !== mem2[16'hFFFF] || memaddr2 !== 16'h0) begin
      bad++; $display("FAIL wrap_first got v=%b pc=%h i=%h a=%h exp 1 ffff %h 0000", ivalid2, ipc2, instr2, memaddr2, mem2[16'hFFFF]);
    end
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    tick(); tick();
    total++;
    if (ivalid2 !== 1'b1 || ipc2 !== 16'h0 || instr2 !== 16'hFFFF || halted2 !== 1'b0) begin
      bad++; $display("FAIL wrap_halt_disabled got v=%b pc=%h i=%h h=%b exp 1 0000 ffff 0", ivalid2, ipc2, instr2, halted2);
    end
    rst_n2 = 1'b0;
    tick();
    rst_n2 = 1'b1;
    total++;
    if (ivalid2 !== 1'b0 || instr2 !== 16'h0 || ipc2 !== 16'h0 || halted2 !== 1'b0 ||
        memread2 !== 1'b0 || memaddr2 !== 16'hFFFF) begin
      bad++; $display("FAIL mid_issue_reset got v=%b i=%h pc=%h h=%b r=%b a=%h exp 0 0000 0000 0 0 ffff",
                      ivalid2, instr2, ipc2, halted2, memread2, memaddr2);
    end
    tick();
    run2 = 1'b1;
    tick();
    run2 = 1'b0;
    total++;
    if (memread2 !== 1'b1 || memaddr2 !== 16'hFFFF) begin
      bad++; $display("FAIL reset_to_idle got r=%b a=%h exp 1 ffff", memread2, memaddr2);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem0[a] = 16'($urandom) & 16'h7FFF;
      mem2[a] = 16'($urandom) & 16'h7FFF;
    end
    mem0[0] = 16'h5101;
    mem0[3] = 16'hFFFF;
    mem2[0] = 16'hFFFF;
    rst_n = 1'b0; run = 1'b0; ready = 1'b0; redir = 1'b0; target = 16'h0;
    rst_n2 = 1'b0; run2 = 1'b0; ready2 = 1'b0; redir2 = 1'b0; target2 = 16'h0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_capture();
    test_redirect_issue();
    test_halt();
    test_random();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
